// File: rtl/hba_quad_pkg.sv
// rtl/hba_quad_pkg.sv - shared register map, bit indices and quadrature step decode for hba_quad
package hba_quad_pkg;

   localparam int COUNT_WIDTH = 16;

   localparam int OFF_CTRL    = 0;
   localparam int OFF_STATUS  = 1;
   localparam int OFF_CNT0_LO = 2;
   localparam int OFF_CNT0_HI = 3;
   localparam int OFF_CNT1_LO = 4;
   localparam int OFF_CNT1_HI = 5;

   localparam int CTRL_EN0    = 0;
   localparam int CTRL_EN1    = 1;
   localparam int CTRL_INT_EN = 2;
   localparam int CTRL_CLR    = 3;

   localparam int STAT_CHG0   = 0;
   localparam int STAT_CHG1   = 1;
   localparam int STAT_ERR0   = 2;
   localparam int STAT_ERR1   = 3;

   typedef enum logic [1:0] {
      STEP_NONE    = 2'b00,
      STEP_INC     = 2'b01,
      STEP_DEC     = 2'b10,
      STEP_ILLEGAL = 2'b11
   } step_e;

   // Position of an {A,B} pair on the 00->01->11->10 cycle (0..3).
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   // Distance between positions: 1 forward, 3 backward, 2 means both bits flipped.
   function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] diff;
      diff = gray_pos(cur_ab) - gray_pos(prev_ab);
      case (diff)
         2'd0:    return STEP_NONE;
         2'd1:    return STEP_INC;
         2'd3:    return STEP_DEC;
         default: return STEP_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/hba_quad_decoder.sv
// rtl/hba_quad_decoder.sv - one quadrature channel: synchronizer, optional QUAD_GLITCH_FILTER_EN filter, x4 decode, 16-bit counter
module hba_quad_decoder
   import hba_quad_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   a,
   input  logic                   b,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   chg,
   output logic                   err
);

   logic [1:0]             sync1_q, sync1_d;
   logic [1:0]             sync2_q, sync2_d;
   logic [1:0]             prev_q, prev_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]             ab_dec;
   step_e                  step;

`ifdef QUAD_GLITCH_FILTER_EN
   logic [1:0] hist0_q, hist0_d;
   logic [1:0] hist1_q, hist1_d;
   logic [1:0] filt_q, filt_d;

   // Each bit only moves once it has held the same level for three samples.
   always_comb begin
      hist0_d = sync2_q;
      hist1_d = hist0_q;
      filt_d  = filt_q;
      for (int i = 0; i < 2; i++) begin
         if ((sync2_q[i] == hist0_q[i]) && (hist0_q[i] == hist1_q[i])) begin
            filt_d[i] = sync2_q[i];
         end
      end
   end

   // Filter history and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hist0_q <= '0;
         hist1_q <= '0;
         filt_q  <= '0;
      end else begin
         hist0_q <= hist0_d;
         hist1_q <= hist1_d;
         filt_q  <= filt_d;
      end
   end

   assign ab_dec = filt_q;
`else
   assign ab_dec = sync2_q;
`endif

   // Synchronize, compare against the previous pair, and step the counter.
   always_comb begin
      sync1_d = {a, b};
      sync2_d = sync1_q;
      prev_d  = ab_dec;
      step    = decode_step(prev_q, ab_dec);
      cnt_d   = cnt_q;
      chg     = 1'b0;
      err     = 1'b0;
      if (en) begin
         case (step)
            STEP_INC: begin
               cnt_d = cnt_q + COUNT_WIDTH'(1);
               chg   = 1'b1;
            end
            STEP_DEC: begin
               cnt_d = cnt_q - COUNT_WIDTH'(1);
               chg   = 1'b1;
            end
            STEP_ILLEGAL: err = 1'b1;
            default: ;
         endcase
      end
      // A pending clear overrides any step landing in the same cycle.
      if (clr) begin
         cnt_d = '0;
      end
   end

   // Channel state registers; previous pair keeps tracking even while disabled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/hba_quad.sv
// rtl/hba_quad.sv - HBA slave with two quadrature counters; QUAD_GLITCH_FILTER_EN enables the input glitch filter
module hba_quad
   import hba_quad_pkg::*;
#(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int PERIPH_ADDR       = 5
)(
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  hba_rnw,
   input  logic                  hba_select,
   input  logic [ADDR_WIDTH-1:0] hba_abus,
   input  logic [DBUS_WIDTH-1:0] hba_dbus,
   output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  hba_xferack_slave,
   output logic                  slave_interrupt,
   input  logic [1:0]            quad_a,
   input  logic [1:0]            quad_b
);

   logic                      hit;
   logic [REG_ADDR_WIDTH-1:0] reg_off;
   logic                      rd_en, wr_en;
   logic                      ack_q, ack_d;
   logic                      done_q, done_d;
   logic                      irq_q, irq_d;
   logic [DBUS_WIDTH-1:0]     rdata_q, rdata_d;
   logic [3:0]                ctrl_q, ctrl_d;
   logic [3:0]                status_q, status_d;
   logic [7:0]                shadow0_q, shadow0_d;
   logic [7:0]                shadow1_q, shadow1_d;
   logic [7:0]                rd_byte;
   logic [COUNT_WIDTH-1:0]    count0, count1;
   logic                      chg0, chg1, err0, err1;
   logic                      unused_dbus;

   assign hit     = hba_select &&
                    (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
   assign reg_off = hba_abus[REG_ADDR_WIDTH-1:0];

   // Only the low nibble of write data carries register bits.
   assign unused_dbus = ^hba_dbus[DBUS_WIDTH-1:4];

   hba_quad_decoder u_dec0 (
      .clk    (hba_clk),
      .resetn (hba_reset),
      .en     (ctrl_q[CTRL_EN0]),
      .clr    (ctrl_q[CTRL_CLR]),
      .a      (quad_a[0]),
      .b      (quad_b[0]),
      .count  (count0),
      .chg    (chg0),
      .err    (err0)
   );

   hba_quad_decoder u_dec1 (
      .clk    (hba_clk),
      .resetn (hba_reset),
      .en     (ctrl_q[CTRL_EN1]),
      .clr    (ctrl_q[CTRL_CLR]),
      .a      (quad_a[1]),
      .b      (quad_b[1]),
      .count  (count1),
      .chg    (chg1),
      .err    (err1)
   );

   // One-cycle ack per hit; re-arm only after select has dropped.
   always_comb begin
      ack_d  = hit && !ack_q && !done_q;
      done_d = hba_select && (done_q || ack_d);
      rd_en  = ack_d && hba_rnw;
      wr_en  = ack_d && !hba_rnw;
   end

   // Read mux; CTRL.clr is write-only and always reads back as 0.
   always_comb begin
      rd_byte = '0;
      case (reg_off)
         REG_ADDR_WIDTH'(OFF_CTRL):    rd_byte = {5'b0, ctrl_q[CTRL_INT_EN], ctrl_q[CTRL_EN1], ctrl_q[CTRL_EN0]};
         REG_ADDR_WIDTH'(OFF_STATUS):  rd_byte = {4'b0, status_q};
         REG_ADDR_WIDTH'(OFF_CNT0_LO): rd_byte = count0[7:0];
         REG_ADDR_WIDTH'(OFF_CNT0_HI): rd_byte = shadow0_q;
         REG_ADDR_WIDTH'(OFF_CNT1_LO): rd_byte = count1[7:0];
         REG_ADDR_WIDTH'(OFF_CNT1_HI): rd_byte = shadow1_q;
         default:                      rd_byte = '0;
      endcase
   end

   // Register writes, W1C status with set-wins, LO-read shadowing and interrupt.
   always_comb begin
      ctrl_d           = ctrl_q;
      ctrl_d[CTRL_CLR] = 1'b0;
      status_d         = status_q;
      shadow0_d        = shadow0_q;
      shadow1_d        = shadow1_q;
      rdata_d          = '0;
      if (wr_en && (reg_off == REG_ADDR_WIDTH'(OFF_CTRL))) begin
         ctrl_d = hba_dbus[3:0];
      end
      if (wr_en && (reg_off == REG_ADDR_WIDTH'(OFF_STATUS))) begin
         status_d = status_q & ~hba_dbus[3:0];
      end
      if (chg0) status_d[STAT_CHG0] = 1'b1;
      if (chg1) status_d[STAT_CHG1] = 1'b1;
      if (err0) status_d[STAT_ERR0] = 1'b1;
      if (err1) status_d[STAT_ERR1] = 1'b1;
      if (rd_en) begin
         rdata_d = DBUS_WIDTH'(rd_byte);
         if (reg_off == REG_ADDR_WIDTH'(OFF_CNT0_LO)) shadow0_d = count0[COUNT_WIDTH-1:8];
         if (reg_off == REG_ADDR_WIDTH'(OFF_CNT1_LO)) shadow1_d = count1[COUNT_WIDTH-1:8];
      end
      irq_d = ctrl_q[CTRL_INT_EN] && (|status_q);
   end

   // Bus-side state registers.
   always_ff @(posedge hba_clk) begin
      if (!hba_reset) begin
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
         ctrl_q    <= '0;
         status_q  <= '0;
         shadow0_q <= '0;
         shadow1_q <= '0;
      end else begin
         ack_q     <= ack_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         ctrl_q    <= ctrl_d;
         status_q  <= status_d;
         shadow0_q <= shadow0_d;
         shadow1_q <= shadow1_d;
      end
   end

   assign hba_xferack_slave = ack_q;
   assign hba_dbus_slave    = rdata_q;
   assign slave_interrupt   = irq_q;

endmodule

// File: tb/tb_hba_quad.sv
// tb/tb_hba_quad.sv - scoreboard bench for hba_quad with directed vectors
module tb_hba_quad;

   localparam int K_WRITE = 0;
   localparam int K_READ  = 1;
   localparam int K_IRQ   = 2;
   localparam int K_QUIET = 3;
   localparam int K_FINAL = 4;

   typedef struct {
      int         kind;
      int         id;
      logic [7:0] data;
      int         issued;
   } exp_t;

   logic        hba_clk = 1'b0;
   logic        hba_reset = 1'b0;
   logic        hba_rnw = 1'b1;
   logic        hba_select = 1'b0;
   logic [11:0] hba_abus = '0;
   logic [7:0]  hba_dbus = '0;
   logic [7:0]  hba_dbus_slave;
   logic        hba_xferack_slave;
   logic        slave_interrupt;
   logic [1:0]  quad_a = '0;
   logic [1:0]  quad_b = '0;

   exp_t xq[$];
   exp_t sq[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   idle_bad = 0;
   int   vid = 0;
   int   ph[2];

   hba_quad dut (
      .hba_clk           (hba_clk),
      .hba_reset         (hba_reset),
      .hba_rnw           (hba_rnw),
      .hba_select        (hba_select),
      .hba_abus          (hba_abus),
      .hba_dbus          (hba_dbus),
      .hba_dbus_slave    (hba_dbus_slave),
      .hba_xferack_slave (hba_xferack_slave),
      .slave_interrupt   (slave_interrupt),
      .quad_a            (quad_a),
      .quad_b            (quad_b)
   );

   always #5 hba_clk = ~hba_clk;

   // Monitor: pops expectations whenever the DUT acks, plus queued side checks.
   always @(negedge hba_clk) begin
      cyc = cyc + 1;
      if (hba_xferack_slave) begin
         if (xq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got ack at cycle %0d, need none", cyc);
         end else begin
            mon_e = xq.pop_front();
            n_vec++;
            if (cyc != mon_e.issued + 2) begin
               n_err++;
               $display("FAIL ack_latency vec %0d: got %0d cycles, need 1", mon_e.id, cyc - mon_e.issued - 1);
            end
            if (mon_e.kind == K_READ) begin
               n_vec++;
               if (hba_dbus_slave !== mon_e.data) begin
                  n_err++;
                  $display("FAIL read_data vec %0d: got %02h, need %02h", mon_e.id, hba_dbus_slave, mon_e.data);
               end
            end
         end
      end else begin
         if (hba_dbus_slave !== 8'h00) idle_bad++;
         if (xq.size() != 0 && cyc >= xq[0].issued + 2) begin
            mon_e = xq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL no_ack vec %0d: got no ack, need ack", mon_e.id);
         end
      end
      while (sq.size() != 0) begin
         mon_e = sq.pop_front();
         n_vec++;
         case (mon_e.kind)
            K_IRQ: begin
               if (slave_interrupt !== mon_e.data[0]) begin
                  n_err++;
                  $display("FAIL irq vec %0d: got %0b, need %0b", mon_e.id, slave_interrupt, mon_e.data[0]);
               end
            end
            K_QUIET: begin
               if ({hba_xferack_slave, slave_interrupt, hba_dbus_slave} !== 10'h0) begin
                  n_err++;
                  $display("FAIL reset_quiet vec %0d: got ack=%0b irq=%0b data=%02h, need all 0",
                           mon_e.id, hba_xferack_slave, slave_interrupt, hba_dbus_slave);
               end
            end
            default: begin
               if (xq.size() != 0 || idle_bad != 0) begin
                  n_err++;
                  $display("FAIL final: got pending=%0d idle_nonzero=%0d, need 0 and 0", xq.size(), idle_bad);
               end
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge hba_clk);
      #1;
   endtask

   task automatic settle();
      repeat (3) tick();
   endtask

   task automatic side(input int kind, input logic [7:0] data);
      exp_t e;
      vid++;
      e.kind = kind; e.id = vid; e.data = data; e.issued = cyc;
      sq.push_back(e);
   endtask

   task automatic bus_idle();
      hba_select = 1'b0;
      hba_rnw    = 1'b1;
      hba_abus   = '0;
      hba_dbus   = '0;
   endtask

   task automatic issue(input logic rnw, input int off, input logic [7:0] wd, input logic [7:0] ed);
      exp_t e;
      logic [7:0] o;
      o = 8'(off);
      vid++;
      hba_select = 1'b1;
      hba_rnw    = rnw;
      hba_abus   = {4'd5, o};
      hba_dbus   = wd;
      e.kind = rnw ? K_READ : K_WRITE; e.id = vid; e.data = ed; e.issued = cyc;
      xq.push_back(e);
   endtask

   task automatic xfer(input logic rnw, input int off, input logic [7:0] wd, input logic [7:0] ed);
      issue(rnw, off, wd, ed);
      tick();
      bus_idle();
      tick();
   endtask

   task automatic rd(input int off, input logic [7:0] ed);
      xfer(1'b1, off, 8'h00, ed);
   endtask

   task automatic wr(input int off, input logic [7:0] wd);
      xfer(1'b0, off, wd, 8'h00);
   endtask

   function automatic logic [1:0] gray(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic set_pos(input int ch, input int p);
      logic [1:0] g;
      ph[ch] = p & 3;
      g = gray(p);
      quad_a[ch] = g[1];
      quad_b[ch] = g[0];
   endtask

   task automatic step(input int ch, input int dir);
      set_pos(ch, ph[ch] + dir);
      tick();
   endtask

   initial begin
      ph[0] = 0;
      ph[1] = 0;
      // Reset state.
      repeat (3) begin
         tick();
         side(K_QUIET, 8'h00);
      end
      hba_reset = 1'b1;
      tick();
      rd(0, 8'h00);
      rd(1, 8'h00);
      rd(2, 8'h00);
      rd(3, 8'h00);

      // Four forward steps on ch0.
      wr(0, 8'h03);
      repeat (4) step(0, 1);
      settle();
      rd(2, 8'h04);
      rd(3, 8'h00);
      rd(1, 8'h01);
      side(K_IRQ, 8'h00);
      wr(1, 8'h0F);

      // One reverse step on ch1 from zero.
      step(1, -1);
      settle();
      rd(4, 8'hFF);
      rd(5, 8'hFF);
      rd(1, 8'h02);
      wr(1, 8'h0F);
      rd(1, 8'h00);

      // Wrap 0xFFFF + 1 -> 0x0000 on ch1.
      step(1, 1);
      settle();
      rd(4, 8'h00);
      rd(5, 8'h00);
      rd(1, 8'h02);
      wr(1, 8'h0F);

      // Disabled channel holds and re-enable adds no step.
      wr(0, 8'h01);
      step(1, 1);
      settle();
      rd(4, 8'h00);
      wr(0, 8'h03);
      settle();
      rd(4, 8'h00);
      rd(5, 8'h00);

      // Illegal 00 -> 11 jump on ch0, interrupt and its W1C clear.
      set_pos(0, 2);
      tick();
      settle();
      rd(2, 8'h04);
      rd(1, 8'h04);
      side(K_IRQ, 8'h00);
      wr(0, 8'h07);
      side(K_IRQ, 8'h01);
      issue(1'b0, 1, 8'h04, 8'h00);
      tick();
      bus_idle();
      side(K_IRQ, 8'h01);
      tick();
      side(K_IRQ, 8'h00);
      rd(1, 8'h00);

      // Clear counters, then coherent snapshot at 0x00FF.
      wr(0, 8'h0B);
      tick();
      rd(2, 8'h00);
      rd(0, 8'h03);
      repeat (255) step(0, 1);
      settle();
      set_pos(0, ph[0] + 1);
      tick();
      tick();
      rd(2, 8'hFF);
      rd(3, 8'h00);
      rd(2, 8'h00);
      rd(3, 8'h01);

      // Reach 0x1234 then clear via CTRL=0x0B.
      repeat (4404) step(0, 1);
      settle();
      rd(2, 8'h34);
      rd(3, 8'h12);
      wr(0, 8'h0B);
      tick();
      rd(2, 8'h00);
      rd(3, 8'h00);
      rd(0, 8'h03);

      // Reset between hit and ack aborts the transfer.
      hba_select = 1'b1;
      hba_rnw    = 1'b1;
      hba_abus   = {4'd5, 8'h00};
      #1;
      hba_reset = 1'b0;
      tick();
      bus_idle();
      side(K_QUIET, 8'h00);
      tick();
      side(K_QUIET, 8'h00);
      hba_reset = 1'b1;
      tick();
      side(K_QUIET, 8'h00);
      rd(9, 8'h00);
      rd(0, 8'h00);
      rd(2, 8'h00);
      rd(5, 8'h00);
      side(K_IRQ, 8'h00);

      tick();
      side(K_FINAL, 8'h00);
      repeat (3) @(negedge hba_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hba_quad.md
HBA_QUAD -- requirements
Module: hba_quad

Interface
REQ-001 The parameters SHALL be as follows:
- DBUS_WIDTH, default 8: data bus width.
- PERIPH_ADDR_WIDTH, default 4: slot-select field width.
- REG_ADDR_WIDTH, default 8: register-offset field width.
- ADDR_WIDTH, default PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: bus address width.
- PERIPH_ADDR, default 5: slot number this block responds to.
REQ-002 The ports SHALL be as follows:
- hba_clk, in, 1: the only clock.
- hba_reset, in, 1: reset; synchronous, active-low.
- hba_rnw, in, 1: 1=read, 0=write.
- hba_select, in, 1: transfer in progress.
- hba_abus, in, ADDR_WIDTH: address bus.
- hba_dbus, in, DBUS_WIDTH: write data bus.
- hba_dbus_slave, out, DBUS_WIDTH: read data; zero when not acking.
- hba_xferack_slave, out, 1: transfer complete; zero when inactive.
- slave_interrupt, out, 1: level interrupt to the interrupt controller.
- quad_a, in, 2: encoder A phase, one bit per channel.
- quad_b, in, 2: encoder B phase, one bit per channel.

Function
REQ-003 The block SHALL decode a hit as hba_select=1 and hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR.
REQ-004 Bus handshake SHALL work as follows:
- A hit in cycle N with ack low asserts hba_xferack_slave in N+1 for exactly one cycle.
- A read drives its data on hba_dbus_slave in N+1 only.
- A write commits at the N+1 clock edge.
- The block does not ack again until hba_select has been low for at least one cycle.
REQ-005 The register map (offset, access) SHALL be:
- 0 CTRL, rw:
  - bit0 en0, bit1 en1;
  - bit2 int_en;
  - bit3 clr, write-1 self-clearing: zeroes both counters one cycle after the write.
- 1 STATUS: bits1:0 chg flags, bits3:2 err flags, all write-1-to-clear; bits7:4 read 0.
- 2 CNT0_LO, ro: the read latches CNT0[15:8] into shadow0.
- 3 CNT0_HI, ro: returns shadow0.
- 4 CNT1_LO and 5 CNT1_HI: same as offsets 2 and 3, for channel 1.
- Other offsets: reads return 0 and are still acked; writes are ignored and acked.
REQ-006 Each input SHALL pass through a 2-flop synchronizer before decode.
REQ-007 Decode SHALL be x4 quadrature, stepping on the previous-to-current synced {A,B} pair:
- 00→01→11→10→00 = +1; the reverse sequence = -1.
- No change = 0.
- Both bits changing = illegal: count unchanged and err[ch] set.
REQ-008 Counters SHALL be 16-bit two's complement, wrapping 0xFFFF+1→0x0000 and 0x0000-1→0xFFFF without error.
REQ-009 When en[ch]=0 the counter SHALL hold; the synchronizer and previous-state registers still track, so re-enabling produces no spurious step.
REQ-010 Any nonzero step SHALL set chg[ch]; if a W1C clear and a set occur in the same cycle, set wins.
REQ-011 If clr coincides with a step, the counter SHALL become 0; clr takes priority.
REQ-012 A step in the same cycle as a CNT_LO read SHALL return and shadow the pre-step value, i.e. a coherent 16-bit snapshot.
REQ-013 slave_interrupt SHALL equal int_en & (|chg | |err), registered, with a 1-cycle lag.

Reset
REQ-014 While hba_reset=0 at a clock edge, all of the following SHALL clear to 0:
- registers, counters, shadows, flags;
- synchronizers and previous-state registers;
- handshake state;
- hba_xferack_slave, hba_dbus_slave and slave_interrupt.
REQ-015 Reset asserted mid-transfer SHALL abort it with no ack, and the next hit after release is served normally.

Configuration
REQ-016 With QUAD_GLITCH_FILTER_EN defined, each synced input SHALL change only after being stable for 3 consecutive cycles, adding 3 cycles of decode latency.
REQ-017 Without QUAD_GLITCH_FILTER_EN, synced inputs SHALL feed decode directly, for a total input-to-count latency of 3 cycles.

Structure
REQ-018 The shared package hba_quad_pkg SHALL hold:
- register offset constants;
- CTRL and STATUS bit indices;
- COUNT_WIDTH=16;
- the step encoding (+1/-1/0/illegal) type.
REQ-019 There SHALL be one sub-module, hba_quad_decoder, instantiated once per channel, containing synchronizer, optional filter, step decode and counter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write CTRL=0x03, apply 4 forward phase steps on ch0, read offsets 2 then 3 → 0x04 then 0x00; STATUS bit0=1.
- Counter at 0x0000, apply 1 reverse step on ch1, read offsets 4 then 5 → 0xFF, 0xFF; no err.
- Apply an {A,B} 00→11 jump on ch0 → count unchanged, STATUS=0x04; with int_en set, slave_interrupt=1; write STATUS=0x04 → interrupt drops 1 cycle later.
- Read CNT0_LO at 0x00FF while a +1 step lands the same cycle → LO=0xFF and HI=0x00; a subsequent LO read returns 0x00 and HI=0x01.
- Write CTRL=0x0B while count=0x1234 → count 0, CTRL reads back 0x03.
- Assert reset between hit and ack → no ack; after release, a read of offset 9 acks in 1 cycle with data 0x00; hba_dbus_slave=0 in all non-ack cycles.
